// File: rtl/trigger_shot_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_shot_ctrl
//
// Shot sequencer for the trigger_gen datapath. Each shot enables trigger_gen,
// waits for the first detect pulse and then the tof-valid pulse (or a timeout),
// queues {timeout, shot index, tof} into a small first-word-fall-through FIFO,
// holds trig_enable low for a programmable hold-off and re-arms.
//
// Ports
//   clk, rst        sole clock; asynchronous active-high reset
//   sw_start        1-cycle start pulse, honoured only in IDLE
//   sw_abort        abort the run; returns to IDLE on the next edge
//   cfg_num_shots   shots per run (0 = continuous until abort)
//   cfg_timeout     max cycles from arm to tof-valid (0 = no timeout)
//   cfg_holdoff     extra low cycles of trig_enable between shots
//   trig_enable     registered enable to trigger_gen
//   detect_pls_0/1  first-pulse / tof-valid flags from trigger_gen
//   pulse_tof       measured time of flight from trigger_gen
//   res_valid/ready result FIFO handshake (pop on valid & ready)
//   res_tof/shot/timeout  head entry of the result FIFO (zero while empty)
//   busy            state != IDLE
//   shot_cnt        shots completed in the current run
//   overflow        sticky: a result was dropped because the FIFO was full
//   state_o         current state encoding, for debug
// -----------------------------------------------------------------------------
module trigger_shot_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int SHOT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_start,
  input  logic              sw_abort,
  input  logic [SHOT_W-1:0] cfg_num_shots,
  input  logic [31:0]       cfg_timeout,
  input  logic [31:0]       cfg_holdoff,
  output logic              trig_enable,
  input  logic              detect_pls_0,
  input  logic              detect_pls_1,
  input  logic [31:0]       pulse_tof,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_tof,
  output logic [SHOT_W-1:0] res_shot,
  output logic              res_timeout,
  output logic              busy,
  output logic [SHOT_W-1:0] shot_cnt,
  output logic              overflow,
  output logic [2:0]        state_o
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = 1 + SHOT_W + 32;
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_MEAS = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [31:0]       timer_reg, timer_next;
  logic [31:0]       hold_cnt_reg, hold_cnt_next;
  logic [SHOT_W-1:0] shot_cnt_reg, shot_cnt_next;
  logic              overflow_reg;
  logic              trig_en_reg;

  // Two-stage registers on the detect inputs; a rise is q & ~qq.
  logic [1:0]        det_q_reg, det_qq_reg;
  logic              rise0, rise1;

  logic              timeout_hit;
  logic              hold_done;
  logic              more_shots;
  logic              start_accept;
  logic              push_req;
  logic              push_timeout;

  // FIFO
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  // ---------------------------------------------------------------------------
  // Detect edge registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_q_reg  <= '0;
      det_qq_reg <= '0;
    end else begin
      det_q_reg  <= {detect_pls_1, detect_pls_0};
      det_qq_reg <= det_q_reg;
    end
  end

  assign rise0 = det_q_reg[0] & ~det_qq_reg[0];
  assign rise1 = det_q_reg[1] & ~det_qq_reg[1];

  // ---------------------------------------------------------------------------
  // Derived conditions
  // ---------------------------------------------------------------------------
  assign timeout_hit = (cfg_timeout != 32'd0) && (timer_reg == cfg_timeout - 32'd1);
  assign hold_done   = (hold_cnt_reg == cfg_holdoff);
  // Compared one bit wider so shot_cnt+1 cannot wrap before the comparison.
  assign more_shots  = (cfg_num_shots == '0) ||
                       (({1'b0, shot_cnt_reg} + 1'b1) < {1'b0, cfg_num_shots});

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      hold_cnt_reg <= '0;
      shot_cnt_reg <= '0;
      trig_en_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      hold_cnt_reg <= hold_cnt_next;
      shot_cnt_reg <= shot_cnt_next;
      // Follows the current state, so it moves one edge after the state;
      // an abort drops it on the same edge as the return to IDLE.
      if (sw_abort)
        trig_en_reg <= 1'b0;
      else
        trig_en_reg <= (state_reg == S_ARM) || (state_reg == S_MEAS);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    hold_cnt_next = '0;
    shot_cnt_next = shot_cnt_reg;
    start_accept  = 1'b0;
    push_req      = 1'b0;
    push_timeout  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (sw_start && !sw_abort) begin
          start_accept  = 1'b1;
          shot_cnt_next = '0;
          timer_next    = '0;
          state_next    = S_ARM;
        end
      end
      S_ARM: begin
        timer_next = timer_reg + 32'd1;
        if (timeout_hit) begin
          push_req     = 1'b1;
          push_timeout = 1'b1;
          state_next   = S_HOLD;
        end else if (rise0) begin
          state_next = S_MEAS;
        end
      end
      S_MEAS: begin
        timer_next = timer_reg + 32'd1;
        // A tof edge in the timeout cycle takes priority over the timeout.
        if (rise1) begin
          push_req   = 1'b1;
          state_next = S_HOLD;
        end else if (timeout_hit) begin
          push_req     = 1'b1;
          push_timeout = 1'b1;
          state_next   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_done) begin
          shot_cnt_next = shot_cnt_reg + 1'b1;
          timer_next    = '0;
          state_next    = more_shots ? S_ARM : S_DONE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 32'd1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (sw_abort && (state_reg != S_IDLE)) begin
      state_next    = S_IDLE;
      push_req      = 1'b0;
      push_timeout  = 1'b0;
      hold_cnt_next = '0;
      shot_cnt_next = shot_cnt_reg;
      timer_next    = timer_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  assign fifo_full  = (count_reg == DEPTH_C);
  assign res_valid  = (count_reg != '0);
  assign pop        = res_valid & res_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign push_ok    = push_req & (~fifo_full | pop);
  assign push_entry = {push_timeout, shot_cnt_reg,
                       (push_timeout ? 32'hFFFF_FFFF : pulse_tof)};

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (start_accept)
        overflow_reg <= 1'b0;
      else if (push_req && !push_ok)
        overflow_reg <= 1'b1;
    end
  end

  // Head fields read as zero while empty so stale RAM contents never show.
  assign head_entry  = res_valid ? mem[rd_ptr_reg] : '0;
  assign res_tof     = head_entry[31:0];
  assign res_shot    = head_entry[32 +: SHOT_W];
  assign res_timeout = head_entry[ENTRY_W-1];

  // ---------------------------------------------------------------------------
  // Status outputs
  // ---------------------------------------------------------------------------
  assign trig_enable = trig_en_reg;
  assign busy        = (state_reg != S_IDLE);
  assign shot_cnt    = shot_cnt_reg;
  assign overflow    = overflow_reg;
  assign state_o     = state_reg;

endmodule
